// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the count timer sequencer.
//   - FSM state encoding (IDLE/RUN/HOLD/DONE)
//   - mode constants (one-shot / periodic)
//   - default counter and prescaler widths
//   - helper to classify busy states
package timer_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PWIDTH = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (presc_q+1) and emits a one-cycle
// tick whenever the internal count matches presc_q while enabled.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   en       in   advance the prescale count (freezes when low)
//   clr      in   force the prescale count back to zero
//   presc_q  in   latched prescale divisor minus 1
//   tick     out  combinational; high on the cycle the count wraps
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [PWIDTH-1:0] presc_q,
  output logic              tick
);

  logic [PWIDTH-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (tick) presc_cnt <= '0;
      else      presc_cnt <= presc_cnt + PWIDTH'(1);
    end
  end

endmodule

// File: rtl/count_timer_ctrl.sv
// count_timer_ctrl: sequencer for a synchronous up-counter with prescaler.
// Latches terminal count, prescale and mode on launch, gates counting,
// detects terminal count and reports status.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, stop, clear  control (priority clear > stop > start)
//   mode                0 one-shot, 1 periodic (latched on launch)
//   tc_val, presc_val   terminal count / prescale-minus-1 (latched on launch)
//   count               current counter value
//   busy, done          status (RUN/HOLD, DONE)
//   tc_pulse            registered one-cycle terminal event pulse
// Optional feature macro TIMER_CAPTURE_EN adds cap_in / cap_val / cap_valid:
// a rising edge on cap_in while busy snapshots count.
//
// state | meaning
// IDLE  | waiting for start, count cleared
// RUN   | counting on prescaler ticks
// HOLD  | paused, count and prescaler frozen
// DONE  | one-shot finished, count held at terminal value
module count_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              mode,
  input  logic [WIDTH-1:0]  tc_val,
  input  logic [PWIDTH-1:0] presc_val,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc_pulse
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic              cap_in,
  output logic [WIDTH-1:0]  cap_val,
  output logic              cap_valid
`endif
);

  state_t            state;
  logic [WIDTH-1:0]  tc_q;
  logic [PWIDTH-1:0] presc_q;
  logic              mode_q;

  logic run_en;
  logic launch;
  logic tick;
  logic terminal;

  assign busy = is_busy(state);
  assign done = (state == ST_DONE);

  // stop and clear both suppress a tick due on the same edge
  assign run_en   = (state == ST_RUN) && !clear && !stop;
  assign launch   = ((state == ST_IDLE) || (state == ST_DONE)) && start && !clear;
  assign terminal = tick && (count == tc_q);

  timer_prescaler #(.PWIDTH(PWIDTH)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (run_en),
    .clr     (clear || launch),
    .presc_q (presc_q),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      tc_q     <= '0;
      presc_q  <= '0;
      mode_q   <= MODE_ONESHOT;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= terminal;
      if (clear) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              tc_q    <= tc_val;
              presc_q <= presc_val;
              mode_q  <= mode;
              count   <= '0;
              state   <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state <= ST_HOLD;
            end else if (tick) begin
              if (count == tc_q) begin
                if (mode_q == MODE_PERIODIC) count <= '0;
                else                         state <= ST_DONE;
              end else begin
                count <= count + WIDTH'(1);
              end
            end
          end
          ST_HOLD: begin
            if (start) state <= ST_RUN;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic cap_d;
  logic cap_rise;

  assign cap_rise = cap_in && !cap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_d     <= 1'b0;
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_d <= cap_in;
      if (clear || launch) begin
        cap_valid <= 1'b0;
      end else if (cap_rise && busy) begin
        cap_val   <= count;
        cap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_count_timer_ctrl.sv
module tb_count_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear, mode;
  logic [3:0] tc_val, presc_val;
  logic [3:0] count;
  logic       busy, done, tc_pulse;
`ifdef TIMER_CAPTURE_EN
  logic       cap_in;
  logic [3:0] cap_val;
  logic       cap_valid;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  count_timer_ctrl #(.WIDTH(4), .PWIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode      (mode),
    .tc_val    (tc_val),
    .presc_val (presc_val),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc_pulse  (tc_pulse)
`ifdef TIMER_CAPTURE_EN
    ,
    .cap_in    (cap_in),
    .cap_val   (cap_val),
    .cap_valid (cap_valid)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_cnt3 [13] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0,
                                4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0; mode = 1'b0;
    tc_val = 4'd0; presc_val = 4'd0;
`ifdef TIMER_CAPTURE_EN
    cap_in = 1'b0;
`endif

    // 1: reset held two cycles with start high
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc_pulse, 0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_idle_count", count, 0);
    chk("rst_idle_busy", busy, 0);

    // 2: one-shot tc=3 presc=0
    mode = 1'b0; tc_val = 4'd3; presc_val = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("os_c0", count, 0);
    chk("os_busy", busy, 1);
    step(); chk("os_c1", count, 1);
    step(); chk("os_c2", count, 2);
    step(); chk("os_c3", count, 3);
    chk("os_done_early", done, 0);
    chk("os_tc_early", tc_pulse, 0);
    step();
    chk("os_done", done, 1);
    chk("os_tc", tc_pulse, 1);
    chk("os_hold3", count, 3);
    chk("os_busy_off", busy, 0);
    step();
    chk("os_tc_low", tc_pulse, 0);
    chk("os_done_held", done, 1);
    chk("os_hold3b", count, 3);

    // 3: periodic tc=2 presc=1 launched from DONE; start in RUN ignored
    mode = 1'b1; tc_val = 4'd2; presc_val = 4'd1; start = 1'b1;
    step(); start = 1'b0;
    chk("per_c0", count, exp_cnt3[0]);
    for (int i = 1; i < 13; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      step();
      chk($sformatf("per_c%0d", i), count, exp_cnt3[i]);
      chk($sformatf("per_tc%0d", i), tc_pulse, (i == 6 || i == 12) ? 1 : 0);
      chk($sformatf("per_busy%0d", i), busy, 1);
    end
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_count", count, 0);

    // 4: periodic tc=5 presc=0, hold at 2 then resume without relatch
    mode = 1'b1; tc_val = 4'd5; presc_val = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("hold_c0", count, 0);
    step(); step();
    chk("hold_c2", count, 2);
    stop = 1'b1;
    tc_val = 4'd1; presc_val = 4'd3; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_frozen%0d", i), count, 2);
      chk($sformatf("hold_busy%0d", i), busy, 1);
    end
    stop = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    chk("resume_c2", count, 2);
    chk("resume_busy", busy, 1);
    step(); chk("resume_c3", count, 3);
    step(); chk("resume_c4", count, 4);
    step(); chk("resume_c5", count, 5);
    step();
    chk("resume_wrap", count, 0);
    chk("resume_tc", tc_pulse, 1);
    chk("resume_periodic", busy, 1);
    clear = 1'b1; step(); clear = 1'b0;

    // 5: one-shot tc=7, clear+start together at count 4
    mode = 1'b0; tc_val = 4'd7; presc_val = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step();
    chk("cs_c4", count, 4);
    clear = 1'b1; start = 1'b1;
    step(); clear = 1'b0;
    chk("cs_count", count, 0);
    chk("cs_busy", busy, 0);
    chk("cs_done", done, 0);
    chk("cs_tc", tc_pulse, 0);
    step(); start = 1'b0;
    chk("cs_relaunch_busy", busy, 1);
    chk("cs_relaunch_c0", count, 0);
    step();
    chk("cs_relaunch_c1", count, 1);
    clear = 1'b1; step(); clear = 1'b0;

    // boundary: tc=0, presc=2 one-shot -> terminal on first tick (3 cycles)
    mode = 1'b0; tc_val = 4'd0; presc_val = 4'd2; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("tc0_not_yet", done, 0);
    step();
    chk("tc0_done", done, 1);
    chk("tc0_pulse", tc_pulse, 1);
    chk("tc0_count", count, 0);
    clear = 1'b1; step(); clear = 1'b0;

`ifdef TIMER_CAPTURE_EN
    // 6: capture at count 6
    mode = 1'b0; tc_val = 4'd9; presc_val = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("cap_c6", count, 6);
    chk("cap_valid_pre", cap_valid, 0);
    cap_in = 1'b1;
    step();
    chk("cap_val", cap_val, 6);
    chk("cap_valid", cap_valid, 1);
    step();
    chk("cap_val_stable", cap_val, 6);
    chk("cap_valid_sticky", cap_valid, 1);
    cap_in = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("cap_valid_clr", cap_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
